// File: rtl/memreg_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin arbitrated memreg path.
package memreg_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ID_W   = 2;

endpackage

// File: rtl/memreg_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, with wrap,
// found by scanning a doubled request vector masked below ptr+1.
module memreg_rr_arbiter_rr_pick
   import memreg_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = DEF_ID_W
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             any
);

   logic [2*N_REQ-1:0] dbl;
   logic [2*N_REQ-1:0] mask;
   logic [2*N_REQ-1:0] cand;

   always_comb begin
      dbl    = {req, req};
      mask   = {(2*N_REQ){1'b1}} << (int'(ptr) + 1);
      cand   = dbl & mask;
      gnt_id = '0;
      any    = 1'b0;
      // Descending scan so the lowest set candidate is the one that sticks.
      for (int j = 2*N_REQ-1; j >= 0; j--) begin
         if (cand[j]) begin
            any    = 1'b1;
            gnt_id = (j >= N_REQ) ? ID_W'(j - N_REQ) : ID_W'(j);
         end
      end
      gnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         gnt[i] = any && (gnt_id == ID_W'(i));
      end
   end

endmodule

// File: rtl/memreg_rr_arbiter.sv
// N-way round-robin arbiter with burst lock feeding a two-stage registered
// data path (stage A = _p0, stage B = _p1) toward one valid/ready consumer.
module memreg_rr_arbiter
   import memreg_rr_arbiter_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ID_W   = DEF_ID_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_last,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [ID_W-1:0]         out_id,
   output logic                    out_last,
   input  logic                    out_ready,
   output logic                    busy
);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   lock_q, lock_d;

   logic [N_REQ-1:0]  pick_gnt;
   logic [ID_W-1:0]   pick_id;
   logic              pick_any;
   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;

   logic              b_free;
   logic              a_can_accept;
   logic              acc;
   logic              acc_last;
   logic [DATA_W-1:0] acc_data;

   logic              vld_p0, vld_p1;
   logic [DATA_W-1:0] data_p0, data_p1;
   logic [ID_W-1:0]   id_p0, id_p1;
   logic              last_p0, last_p1;

   memreg_rr_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr_q),
      .gnt    (pick_gnt),
      .gnt_id (pick_id),
      .any    (pick_any)
   );

   // Grant: free round-robin in IDLE, locked owner only in BURST.
   always_comb begin
      gnt    = '0;
      gnt_id = pick_id;
      if (state_q == BURST) begin
         gnt_id = lock_q;
         for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = req_valid[i] && (lock_q == ID_W'(i));
         end
      end else if (pick_any) begin
         gnt = pick_gnt;
      end
   end

   assign b_free       = out_ready || !vld_p1;
   assign a_can_accept = !vld_p0 || b_free;
   assign req_ready    = reset ? '0 : (gnt & {N_REQ{a_can_accept}});
   assign acc          = |req_ready;

   always_comb begin
      acc_data = req_data[int'(gnt_id)*DATA_W +: DATA_W];
      acc_last = req_last[gnt_id];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      if (acc) begin
         if (acc_last) begin
            ptr_d   = gnt_id;
            state_d = IDLE;
         end else if (state_q == IDLE) begin
            lock_d  = gnt_id;
            state_d = BURST;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= ID_W'(N_REQ - 1);
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   // Stage A payload: only meaningful while vld_p0 is set.
   always_ff @(posedge clk) begin
      if (acc) begin
         data_p0 <= acc_data;
         id_p0   <= gnt_id;
         last_p0 <= acc_last;
      end
   end

   // Stage A/B occupancy and stage B payload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         id_p1   <= '0;
         last_p1 <= 1'b0;
      end else begin
         if (b_free) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
               data_p1 <= data_p0;
               id_p1   <= id_p0;
               last_p1 <= last_p0;
            end
         end
         if (a_can_accept) begin
            vld_p0 <= acc;
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_id    = id_p1;
   assign out_last  = last_p1;
   assign busy      = (state_q == BURST) || vld_p0 || vld_p1;

endmodule

// File: tb/tb_memreg_rr_arbiter.sv
// Scoreboard bench for memreg_rr_arbiter: directed scenarios plus a random run.
module tb_memreg_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_last = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_id;
   logic            out_last;
   logic            out_ready = 1'b0;
   logic            busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [IW-1:0] id;
      logic          last;
   } word_t;

   word_t expq[$];
   int    obs_id[$];
   int    obs_data[$];

   // Reference model state: arbitration pointer/lock and which stages hold words.
   int m_ptr   = N - 1;
   int m_lock  = 0;
   bit m_burst = 1'b0;
   bit a_full  = 1'b0;
   bit b_full  = 1'b0;

   always #5 clk = ~clk;

   memreg_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v);
      logic [N-1:0] g;
      g = '0;
      if (m_burst) begin
         if (v[m_lock]) g[m_lock] = 1'b1;
         return g;
      end
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (v[i]) begin
            g[i] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   // Model: predict req_ready/out_valid/busy, record accepted words, advance.
   always @(negedge clk) begin
      logic [N-1:0] g, er;
      bit can, bfree;
      if (reset) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         m_ptr = N - 1; m_lock = 0; m_burst = 1'b0;
         a_full = 1'b0; b_full = 1'b0;
         expq.delete();
      end else begin
         g   = exp_grant(req_valid);
         can = !a_full || !b_full || out_ready;
         er  = can ? g : '0;
         chk("req_ready", req_ready, er);
         chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
         chk("out_valid", out_valid, b_full);
         chk("busy", busy, (m_burst || a_full || b_full));
         bfree = out_ready || !b_full;
         if (er != 0) begin
            for (int i = 0; i < N; i++) begin
               if (er[i]) begin
                  expq.push_back({req_data[i*DW +: DW], IW'(i), req_last[i]});
                  if (req_last[i]) begin
                     m_ptr = i; m_burst = 1'b0;
                  end else if (!m_burst) begin
                     m_lock = i; m_burst = 1'b1;
                  end
               end
            end
         end
         if (bfree) b_full = a_full;
         if (can) a_full = (er != 0);
      end
   end

   // Monitor: compare each consumed word against the scoreboard head.
   always @(negedge clk) begin
      word_t w;
      if (!reset && out_valid && out_ready) begin
         obs_id.push_back(int'(out_id));
         obs_data.push_back(int'(out_data));
         if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output actual=%0h required=none", out_data);
         end else begin
            w = expq.pop_front();
            chk("out_data", out_data, w.d);
            chk("out_id", out_id, w.id);
            chk("out_last", out_last, w.last);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0; req_last = '0; out_ready = 1'b0;
      cyc(); cyc();
      obs_id.delete(); obs_data.delete();
      reset = 1'b0;
   endtask

   task automatic set_word(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   int sent;
   logic [N-1:0] rv3 [5] = '{4'b0100, 4'b0101, 4'b0001, 4'b0101, 4'b0001};
   logic [N-1:0] rl3 [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0001};

   initial begin
      // 1: single word latency
      do_reset();
      req_valid = 4'b0001; req_last = 4'b0001; out_ready = 1'b1;
      set_word(0, 32'hA5A5_0001);
      #1 chk("t1_req_ready", req_ready, 4'b0001);
      cyc();
      req_valid = '0;
      chk("t1_out_valid_k", out_valid, 0);
      cyc();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, 32'hA5A5_0001);
      chk("t1_out_id", out_id, 0);
      chk("t1_out_last", out_last, 1);
      cyc(); cyc();

      // 2: rotating grant among four single-beat requesters
      do_reset();
      out_ready = 1'b1; req_valid = 4'b1111; req_last = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) set_word(i, 32'hB000_0000 + 32'(c*16 + i));
         #1 chk("t2_grant", req_ready, 4'b0001 << (c % 4));
         cyc();
      end
      req_valid = '0;
      repeat (4) cyc();

      // 3: burst lock from requester 2, including a valid gap
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         req_valid = rv3[c]; req_last = rl3[c];
         set_word(0, 32'hC000_0000 + 32'(c));
         set_word(2, 32'hC200_0000 + 32'(c));
         #1;
         if (c < 4) chk("t3_req0_blocked", req_ready[0], 0);
         cyc();
      end
      req_valid = '0;
      repeat (5) cyc();
      chk("t3_count", obs_id.size(), 4);
      if (obs_id.size() == 4) begin
         chk("t3_id0", obs_id[0], 2);
         chk("t3_id1", obs_id[1], 2);
         chk("t3_id2", obs_id[2], 2);
         chk("t3_id3", obs_id[3], 0);
      end

      // 4: backpressure fills both stages, then drains in order
      do_reset();
      out_ready = 1'b0; req_valid = 4'b0010; req_last = 4'b0010; sent = 0;
      for (int c = 0; c < 5; c++) begin
         set_word(1, 32'h10 + 32'(sent));
         #1 if (req_ready[1]) sent++;
         cyc();
      end
      set_word(1, 32'h10 + 32'(sent));
      #1;
      chk("t4_accepted", sent, 2);
      chk("t4_ready_low", req_ready, 0);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sent < 3; c++) begin
         set_word(1, 32'h10 + 32'(sent));
         #1 if (req_ready[1]) sent++;
         cyc();
      end
      req_valid = '0;
      chk("t4_third_sent", sent, 3);
      repeat (5) cyc();
      chk("t4_count", obs_data.size(), 3);
      if (obs_data.size() == 3) begin
         chk("t4_d0", obs_data[0], 32'h10);
         chk("t4_d1", obs_data[1], 32'h11);
         chk("t4_d2", obs_data[2], 32'h12);
      end

      // 5: asynchronous reset in the middle of a stalled burst
      do_reset();
      out_ready = 1'b0; req_valid = 4'b0100; req_last = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         set_word(2, 32'hD200_0000 + 32'(c));
         cyc();
      end
      chk("t5_full_before", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_req_ready", req_ready, 0);
      chk("t5_busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
      #1 chk("t5_first_winner", req_ready, 4'b0001);
      cyc();
      req_valid = '0;
      repeat (4) cyc();

      // 6: random traffic against the model
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         req_valid = N'($urandom_range(0, 15));
         req_last  = N'($urandom);
         for (int i = 0; i < N; i++) set_word(i, $urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         cyc();
      end
      req_valid = '0; out_ready = 1'b1;
      repeat (6) cyc();
      chk("drain_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
